// File: rtl/toon_pkg.sv
// toon_pkg: render mode enum plus posterise/luma helpers shared by the toon pixel path
package toon_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_POSTER, MODE_TOON, MODE_EDGE} mode_t;
  localparam int MAXW = 32;
  function automatic logic [MAXW-1:0] posterise(input logic [MAXW-1:0] c, input int cw, input int qbits, input int ow);
    logic [MAXW-1:0] b;
    b = ((c >> (cw - qbits)) << 1) | MAXW'(1);
    return b << (ow - qbits - 1);
  endfunction
  function automatic logic [MAXW+1:0] luma(input logic [MAXW-1:0] r, input logic [MAXW-1:0] g, input logic [MAXW-1:0] b);
    return ({2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b}) >> 2;
  endfunction
endpackage

// File: rtl/toon_sync_fifo.sv
// toon_sync_fifo: DEPTH-entry sync FIFO (i_push/i_wdata in, i_pop/o_rdata head out, o_full/o_empty/o_level status, i_rst/i_clear flush)
module toon_sync_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign o_full = o_level == LW'(DEPTH);
  assign o_empty = o_level == '0;
  assign push_ok = i_push && !o_full && !i_rst && !i_clear;
  assign pop_ok = i_pop && !o_empty;
  assign o_rdata = mem[rd_ptr];
  always_ff @(posedge i_clk)
    if (push_ok) mem[wr_ptr] <= i_wdata;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      o_level <= o_level + LW'(push_ok) - LW'(pop_ok);
    end
  end
endmodule

// File: rtl/toon_pixel_pipe.sv
// toon_pixel_pipe: pairs buffered RGB pixels with edge samples, renders PASS/POSTER/TOON/EDGE into a registered o_valid/i_ready output with luma, level and sticky overflow
module toon_pixel_pipe
  import toon_pkg::*;
#(
  parameter int CW = 8,
  parameter int QBITS = 3,
  parameter int EW = 4,
  parameter int DEPTH = 16,
  parameter int OW = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic [1:0]             i_mode,
  input  logic [EW-1:0]          i_thresh,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  input  logic [CW-1:0]          i_pix_r,
  input  logic [CW-1:0]          i_pix_g,
  input  logic [CW-1:0]          i_pix_b,
  input  logic                   i_edge_valid,
  output logic                   o_edge_ready,
  input  logic [EW-1:0]          i_edge,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [OW-1:0]          o_red,
  output logic [OW-1:0]          o_green,
  output logic [OW-1:0]          o_blue,
  output logic [CW-1:0]          o_luma,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);
  logic full, empty, push, pop, hit;
  logic [3*CW-1:0] head;
  logic [CW-1:0] src [3];
  logic [OW-1:0] nxt [3];
  logic [OW-1:0] out_c [3];
  logic [OW-1:0] edge_c;
  logic [CW-1:0] luma_n;
  mode_t mode;
  assign o_pix_ready = !i_rst && !full;
  assign o_edge_ready = !empty && (!o_valid || i_ready);
  assign push = i_pix_valid && o_pix_ready;
  assign pop = i_edge_valid && o_edge_ready;
  toon_sync_fifo #(.W(3*CW), .DEPTH(DEPTH)) u_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clear(i_clear),
    .i_push(push),
    .i_pop(pop),
    .i_wdata({i_pix_r, i_pix_g, i_pix_b}),
    .o_rdata(head),
    .o_full(full),
    .o_empty(empty),
    .o_level(o_level)
  );
  assign src[0] = head[3*CW-1 -: CW];
  assign src[1] = head[2*CW-1 -: CW];
  assign src[2] = head[CW-1 -: CW];
  assign mode = mode_t'(i_mode);
  assign hit = i_edge >= i_thresh;
  assign edge_c = OW'(i_edge) << (OW - EW);
  assign luma_n = CW'(luma(MAXW'(src[0]), MAXW'(src[1]), MAXW'(src[2])));
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [OW-1:0] pass_c, post_c;
    assign pass_c = OW'(src[i]) << (OW - CW);
    assign post_c = OW'(posterise(MAXW'(src[i]), CW, QBITS, OW));
    assign nxt[i] = mode == MODE_PASS ? pass_c :
                    mode == MODE_POSTER ? post_c :
                    mode == MODE_TOON ? (hit ? '0 : post_c) : edge_c;
  end
  assign o_red = out_c[0];
  assign o_green = out_c[1];
  assign o_blue = out_c[2];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      out_c <= '{default: '0};
      o_luma <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_pix_valid && full) o_overflow <= 1'b1;
      if (i_clear) o_valid <= 1'b0;
      else if (pop) begin
        o_valid <= 1'b1;
        out_c <= nxt;
        o_luma <= luma_n;
      end else if (i_ready) o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_toon_pixel_pipe.sv
// tb_toon_pixel_pipe: directed self-checking bench for toon_pixel_pipe
module tb_toon_pixel_pipe;
  localparam int CW = 8, QBITS = 3, EW = 4, DEPTH = 16, OW = 10, LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [EW-1:0] thresh = '0, edge_v = '0;
  logic pix_valid = 1'b0, edge_valid = 1'b0, ready = 1'b1;
  logic [CW-1:0] pr = '0, pg = '0, pb = '0;
  logic pix_ready, edge_ready, valid, overflow;
  logic [OW-1:0] red, green, blue;
  logic [CW-1:0] luma;
  logic [LW-1:0] level;
  int vecs = 0, errs = 0;

  toon_pixel_pipe #(.CW(CW), .QBITS(QBITS), .EW(EW), .DEPTH(DEPTH), .OW(OW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_mode(mode), .i_thresh(thresh),
    .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
    .i_pix_r(pr), .i_pix_g(pg), .i_pix_b(pb),
    .i_edge_valid(edge_valid), .o_edge_ready(edge_ready), .i_edge(edge_v),
    .o_valid(valid), .i_ready(ready),
    .o_red(red), .o_green(green), .o_blue(blue), .o_luma(luma),
    .o_level(level), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] gr(input int k);
    return CW'(k * 3 + 1);
  endfunction
  function automatic logic [CW-1:0] gb(input int k);
    return CW'(255 - k);
  endfunction

  task automatic push_px(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
    pix_valid = 1'b1;
    pr = r;
    pg = g;
    pb = b;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic push_seq(input int base, input int n);
    for (int k = 0; k < n; k++) push_px(gr(base + k), CW'(base + k), gb(base + k));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", valid); end
    vecs++; if ({red, green, blue, luma} !== '0) begin errs++; $display("FAIL reset_data got %h %h %h %h want 0", red, green, blue, luma); end
    vecs++; if (level !== '0 || overflow !== 1'b0) begin errs++; $display("FAIL reset_status got level %0d ovf %b want 0 0", level, overflow); end
    vecs++; if (pix_ready !== 1'b0 || edge_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b %b want 0 0", pix_ready, edge_ready); end
    rst = 1'b0;
    tick();
    vecs++; if (pix_ready !== 1'b1) begin errs++; $display("FAIL reset_release got %b want 1", pix_ready); end
    vecs++; if (edge_ready !== 1'b0) begin errs++; $display("FAIL reset_edge_ready got %b want 0", edge_ready); end
  endtask

  task automatic test_pass();
    mode = 2'd0;
    push_px(8'hFF, 8'h80, 8'h01);
    edge_valid = 1'b1;
    edge_v = 4'd0;
    vecs++; if (edge_ready !== 1'b1 || valid !== 1'b0) begin errs++; $display("FAIL pass_pre got er %b v %b want 1 0", edge_ready, valid); end
    tick();
    edge_valid = 1'b0;
    vecs++; if (valid !== 1'b1) begin errs++; $display("FAIL pass_valid got %b want 1", valid); end
    vecs++; if (red !== 10'h3FC || green !== 10'h200 || blue !== 10'h004) begin errs++; $display("FAIL pass_rgb got %h %h %h want 3fc 200 004", red, green, blue); end
    vecs++; if (luma !== 8'h80) begin errs++; $display("FAIL pass_luma got %h want 80", luma); end
    tick();
    vecs++; if (valid !== 1'b0 || level !== '0) begin errs++; $display("FAIL pass_drain got v %b lvl %0d want 0 0", valid, level); end
  endtask

  task automatic test_toon();
    mode = 2'd2;
    thresh = 4'd8;
    push_px(8'hA0, 8'h40, 8'h20);
    push_px(8'hA0, 8'h40, 8'h20);
    edge_valid = 1'b1;
    edge_v = 4'd7;
    tick();
    vecs++; if (red !== 10'h2C0 || green !== 10'h140 || blue !== 10'h0C0) begin errs++; $display("FAIL toon_below got %h %h %h want 2c0 140 0c0", red, green, blue); end
    vecs++; if (luma !== 8'h50) begin errs++; $display("FAIL toon_luma got %h want 50", luma); end
    edge_v = 4'd8;
    tick();
    edge_valid = 1'b0;
    vecs++; if (valid !== 1'b1 || {red, green, blue} !== '0) begin errs++; $display("FAIL toon_edge got v %b %h %h %h want 1 0 0 0", valid, red, green, blue); end
    vecs++; if (luma !== 8'h50) begin errs++; $display("FAIL toon_edge_luma got %h want 50", luma); end
    mode = 2'd3;
    push_px(8'h11, 8'h22, 8'h33);
    edge_valid = 1'b1;
    edge_v = 4'hB;
    tick();
    edge_valid = 1'b0;
    vecs++; if (red !== 10'h2C0 || green !== 10'h2C0 || blue !== 10'h2C0) begin errs++; $display("FAIL edge_mode got %h %h %h want 2c0 x3", red, green, blue); end
    mode = 2'd1;
    push_px(8'h1F, 8'hE0, 8'h7F);
    edge_valid = 1'b1;
    tick();
    edge_valid = 1'b0;
    vecs++; if (red !== 10'h040 || green !== 10'h3C0 || blue !== 10'h1C0) begin errs++; $display("FAIL poster_mode got %h %h %h want 040 3c0 1c0", red, green, blue); end
    tick();
  endtask

  task automatic test_full();
    mode = 2'd0;
    push_seq(0, DEPTH + 1);
    vecs++; if (level !== LW'(DEPTH)) begin errs++; $display("FAIL full_level got %0d want %0d", level, DEPTH); end
    vecs++; if (overflow !== 1'b1 || pix_ready !== 1'b0) begin errs++; $display("FAIL full_flags got ovf %b rdy %b want 1 0", overflow, pix_ready); end
    edge_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      vecs++; if (red !== {gr(k), 2'b00} || blue !== {gb(k), 2'b00} || valid !== 1'b1) begin errs++; $display("FAIL full_order%0d got v %b %h %h want 1 %h %h", k, valid, red, blue, {gr(k), 2'b00}, {gb(k), 2'b00}); end
    end
    vecs++; if (level !== '0 || edge_ready !== 1'b0) begin errs++; $display("FAIL full_empty got lvl %0d er %b want 0 0", level, edge_ready); end
    tick();
    edge_valid = 1'b0;
    vecs++; if (valid !== 1'b0 || overflow !== 1'b1) begin errs++; $display("FAIL full_after got v %b ovf %b want 0 1", valid, overflow); end
  endtask

  task automatic test_back_to_back();
    push_seq(40, 3);
    ready = 1'b0;
    edge_valid = 1'b1;
    tick();
    vecs++; if (valid !== 1'b1 || edge_ready !== 1'b0) begin errs++; $display("FAIL bp_stall got v %b er %b want 1 0", valid, edge_ready); end
    tick();
    tick();
    vecs++; if (red !== {gr(40), 2'b00} || level !== LW'(2)) begin errs++; $display("FAIL bp_stable got %h lvl %0d want %h 2", red, level, {gr(40), 2'b00}); end
    ready = 1'b1;
    tick();
    vecs++; if (valid !== 1'b1 || red !== {gr(41), 2'b00} || level !== LW'(1)) begin errs++; $display("FAIL bp_rel1 got v %b %h lvl %0d want 1 %h 1", valid, red, level, {gr(41), 2'b00}); end
    tick();
    vecs++; if (valid !== 1'b1 || red !== {gr(42), 2'b00} || level !== '0) begin errs++; $display("FAIL bp_rel2 got v %b %h lvl %0d want 1 %h 0", valid, red, level, {gr(42), 2'b00}); end
    tick();
    edge_valid = 1'b0;
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL bp_drain got %b want 0", valid); end
    push_seq(50, 2);
    pix_valid = 1'b1;
    pr = gr(52);
    pg = CW'(52);
    pb = gb(52);
    edge_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    edge_valid = 1'b0;
    vecs++; if (level !== LW'(2) || red !== {gr(50), 2'b00}) begin errs++; $display("FAIL bp_pushpop got lvl %0d %h want 2 %h", level, red, {gr(50), 2'b00}); end
    edge_valid = 1'b1;
    tick();
    tick();
    edge_valid = 1'b0;
    vecs++; if (red !== {gr(52), 2'b00} || level !== '0) begin errs++; $display("FAIL bp_pushpop_tail got %h lvl %0d want %h 0", red, level, {gr(52), 2'b00}); end
    tick();
  endtask

  task automatic test_clear();
    push_seq(60, 6);
    ready = 1'b0;
    edge_valid = 1'b1;
    tick();
    edge_valid = 1'b0;
    vecs++; if (level !== LW'(5) || valid !== 1'b1) begin errs++; $display("FAIL clr_pre got lvl %0d v %b want 5 1", level, valid); end
    clr = 1'b1;
    pix_valid = 1'b1;
    pr = gr(70);
    tick();
    clr = 1'b0;
    pix_valid = 1'b0;
    vecs++; if (level !== '0 || valid !== 1'b0) begin errs++; $display("FAIL clr_flush got lvl %0d v %b want 0 0", level, valid); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL clr_ovf got %b want 1", overflow); end
    tick();
    vecs++; if (level !== '0 || edge_ready !== 1'b0) begin errs++; $display("FAIL clr_after got lvl %0d er %b want 0 0", level, edge_ready); end
    ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_toon();
    test_full();
    test_back_to_back();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
